// File: rtl/tile_renderer_pkg.sv
// tile_renderer_pkg: shared types for the tile renderer.
//   opcode_e          command opcodes carried in cmd[31:28]
//   state_e           command/fill FSM states
//   rgb_t             24-bit RGB triple
//   rgb565_to_rgb888  expands RGB565 to RGB888 by MSB replication
package tile_renderer_pkg;

  localparam int unsigned PIX_W = 10;

  typedef enum logic [3:0] {
    OP_WRITE_TILE  = 4'h2,
    OP_FILL        = 4'h3,
    OP_SET_PALETTE = 4'h4
  } opcode_e;

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t rgb565_to_rgb888(input logic [15:0] c);
    rgb_t o;
    o.r = {c[15:11], c[15:13]};
    o.g = {c[10:5],  c[10:9]};
    o.b = {c[4:0],   c[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/tile_renderer_tile_map_ram.sv
// tile_map_ram: simple dual-port RAM, synchronous read-first, no reset.
//   clk          clock
//   we/waddr/wdata  write port
//   raddr/rdata  read port (rdata registered; same-address write returns old data)
module tile_map_ram #(
  parameter int unsigned DEPTH = 1200,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: tile-map + palette colour mapper with a command port.
//   clk, reset           clock, asynchronous active-high reset
//   blank, x, y          raster input (blank = 0 forces black)
//   cmd_valid/cmd_ready  command handshake, cmd = 32-bit command word
//   busy                 fill engine running
//   red, green, blue     RGB888 output, 2 clocks after x/y/blank
// Optional feature macro: RESET_CLEAR_EN (fill map with index 0 after reset).
module tile_renderer
  import tile_renderer_pkg::*;
#(
  parameter int unsigned TILE_LOG2 = 4,
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned IDX_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blank,
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd,
  output logic             busy,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue
);

  localparam int unsigned   DEPTH     = COLS * ROWS;
  localparam int unsigned   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   PAL_N     = 1 << IDX_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e           state, state_nxt;
  logic [AW-1:0]    fill_cnt;
  logic [IDX_W-1:0] fill_idx;
  logic             accept;
  logic [3:0]       op;
  logic             clr_hold;

  logic [5:0]       wt_col, wt_row;
  logic             wt_in_map;
  logic [AW-1:0]    wt_addr_c;
  logic             wt_pend;
  logic [AW-1:0]    wt_addr;
  logic [IDX_W-1:0] wt_data;

  rgb_t             palette [PAL_N];

  logic             ram_we;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [IDX_W-1:0] ram_wdata, ram_rdata;

  logic [PIX_W-1:0] tcol, trow;
  logic             pix_in_range;
  logic             s1_in_range, s1_blank;
  rgb_t             pal_rgb, rgb_q;

  assign op     = cmd[31:28];
  assign accept = cmd_valid && cmd_ready;

`ifdef RESET_CLEAR_EN
  logic clr_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_pend <= 1'b1;
    end else if (state == IDLE) begin
      clr_pend <= 1'b0;
    end
  end

  // Gated by reset so cmd_ready still reads 1 while reset is held.
  assign clr_hold = clr_pend && !reset;
`else
  assign clr_hold = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !clr_hold;
        if (clr_hold) begin
          state_nxt = FILL;
        end else if (cmd_valid && op == OP_FILL) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (fill_cnt == LAST_ADDR) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
      fill_idx <= '0;
    end else if (state == IDLE) begin
      fill_cnt <= '0;
      if (clr_hold) begin
        fill_idx <= '0;
      end else if (accept && op == OP_FILL) begin
        fill_idx <= cmd[IDX_W-1:0];
      end
    end else if (fill_cnt != LAST_ADDR) begin
      fill_cnt <= fill_cnt + AW'(1);
    end
  end

  // ---------------- WRITE_TILE ----------------
  assign wt_col    = cmd[27:22];
  assign wt_row    = cmd[21:16];
  assign wt_in_map = (32'(wt_col) < COLS) && (32'(wt_row) < ROWS);
  assign wt_addr_c = AW'(32'(wt_row) * COLS + 32'(wt_col));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wt_pend <= 1'b0;
      wt_addr <= '0;
      wt_data <= '0;
    end else begin
      wt_pend <= accept && op == OP_WRITE_TILE && wt_in_map;
      if (accept && op == OP_WRITE_TILE) begin
        wt_addr <= wt_addr_c;
        wt_data <= cmd[IDX_W-1:0];
      end
    end
  end

  // A pending tile write can never coincide with FILL: FILL is only
  // entered from IDLE one cycle after any earlier acceptance has retired.
  always_comb begin
    ram_we    = wt_pend;
    ram_waddr = wt_addr;
    ram_wdata = wt_data;
    if (state == FILL) begin
      ram_we    = 1'b1;
      ram_waddr = fill_cnt;
      ram_wdata = fill_idx;
    end
  end

  // ---------------- Palette ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PAL_N; i++) begin
        palette[i] <= '0;
      end
    end else if (accept && op == OP_SET_PALETTE) begin
      palette[cmd[20 +: IDX_W]] <= rgb565_to_rgb888(cmd[15:0]);
    end
  end

  // ---------------- Pixel pipeline ----------------
  // Stage 0: the RAM's registered read port acts as the address register.
  assign tcol         = x >> TILE_LOG2;
  assign trow         = y >> TILE_LOG2;
  assign pix_in_range = (32'(tcol) < COLS) && (32'(trow) < ROWS);
  assign ram_raddr    = pix_in_range ? AW'(32'(trow) * COLS + 32'(tcol)) : '0;

  tile_map_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W),
    .AW    (AW)
  ) u_map (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_in_range <= 1'b0;
      s1_blank    <= 1'b0;
    end else begin
      s1_in_range <= pix_in_range;
      s1_blank    <= blank;
    end
  end

  // Stage 1: lookup reads the pre-write palette, so a same-cycle
  // SET_PALETTE shows the old colour for this pixel.
  assign pal_rgb = palette[ram_rdata];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (s1_blank && s1_in_range) begin
      rgb_q <= pal_rgb;
    end else begin
      rgb_q <= '0;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_tile_renderer.sv
module tb_tile_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        blank;
  logic [9:0]  x, y;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd;
  logic        busy;
  logic [7:0]  red, green, blue;

  int checks = 0;
  int errors = 0;

  tile_renderer #(
    .TILE_LOG2 (4),
    .COLS      (40),
    .ROWS      (30),
    .IDX_W     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .blank     (blank),
    .x         (x),
    .y         (y),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .busy      (busy),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic drive_pix(input logic [9:0] px, input logic [9:0] py, input logic pb);
    x = px;
    y = py;
    blank = pb;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] c);
    int n;
    cmd = c;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    blank = 1'b1;
    x = '0;
    y = '0;
    cmd_valid = 1'b0;
    cmd = '0;
    #3;
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: rgb=%h required %h", {red, green, blue}, 24'h0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
`ifdef RESET_CLEAR_EN
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL reset_clear_len: busy cycles=%0d required 1200", n);
    end
`else
    n = 0;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ready=%b required 0 1", busy, cmd_ready);
    end
`endif
  endtask

  task automatic test_fill();
    int n;
    logic [9:0] px [3];
    logic [9:0] py [3];
    px[0] = 10'd0;   py[0] = 10'd0;
    px[1] = 10'd639; py[1] = 10'd479;
    px[2] = 10'd100; py[2] = 10'd200;
    send_cmd(32'h4050_F800);
    send_cmd(32'h3000_0005);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_low: cmd_ready=%b required 0", cmd_ready);
    end
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL fill_len: busy cycles=%0d required 1200", n);
    end
    for (int i = 0; i < 3; i++) begin
      drive_pix(px[i], py[i], 1'b1);
      checks++;
      if ({red, green, blue} !== 24'hFF0000) begin
        errors++;
        $display("FAIL fill_pix(%0d,%0d): rgb=%h required %h", px[i], py[i], {red, green, blue}, 24'hFF0000);
      end
    end
  endtask

  task automatic test_write_tile();
    logic [9:0]  px [5];
    logic [9:0]  py [5];
    logic [23:0] ex [5];
    px[0] = 10'd48; py[0] = 10'd32; ex[0] = 24'h00FF00;
    px[1] = 10'd63; py[1] = 10'd47; ex[1] = 24'h00FF00;
    px[2] = 10'd55; py[2] = 10'd40; ex[2] = 24'h00FF00;
    px[3] = 10'd47; py[3] = 10'd32; ex[3] = 24'hFF0000;
    px[4] = 10'd64; py[4] = 10'd32; ex[4] = 24'hFF0000;
    send_cmd(32'h20C2_0007);
    send_cmd(32'h4070_07E0);
    for (int i = 0; i < 5; i++) begin
      drive_pix(px[i], py[i], 1'b1);
      checks++;
      if ({red, green, blue} !== ex[i]) begin
        errors++;
        $display("FAIL wt_pix(%0d,%0d): rgb=%h required %h", px[i], py[i], {red, green, blue}, ex[i]);
      end
    end
  endtask

  task automatic test_blank();
    drive_pix(10'd50, 10'd35, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL blank_lit: rgb=%h required %h", {red, green, blue}, 24'h00FF00);
    end
    blank = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL blank_lat1: rgb=%h required %h", {red, green, blue}, 24'h00FF00);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL blank_lat2: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
    blank = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL unblank_lat1: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL unblank_lat2: rgb=%h required %h", {red, green, blue}, 24'h00FF00);
    end
  endtask

  task automatic test_out_of_range();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready_before: cmd_ready=%b required 1", cmd_ready);
    end
    send_cmd(32'h2B40_0007);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_ready_after: cmd_ready=%b required 1", cmd_ready);
    end
    // col 45 row 0 would alias tile (5,1) if written unchecked
    drive_pix(10'd80, 10'd16, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL oor_alias: rgb=%h required %h", {red, green, blue}, 24'hFF0000);
    end
    send_cmd(32'h1FFF_FFFF);
    drive_pix(10'd48, 10'd32, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL nop_opcode: rgb=%h required %h", {red, green, blue}, 24'h00FF00);
    end
    drive_pix(10'd640, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL oor_x640: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
    drive_pix(10'd0, 10'd480, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL oor_y480: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_start: cmd_ready=%b required 1", cmd_ready);
    end
    cmd = 32'h3000_0005;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd = 32'h2000_0007;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL b2b_not_ready_len: cycles=%0d required 1200", n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: cmd_ready=%b required 1", i, cmd_ready);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    drive_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL b2b_tile00: rgb=%h required %h", {red, green, blue}, 24'h00FF00);
    end
    drive_pix(10'd16, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL b2b_tile10: rgb=%h required %h", {red, green, blue}, 24'hFF0000);
    end
    drive_pix(10'd48, 10'd32, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL b2b_refill: rgb=%h required %h", {red, green, blue}, 24'hFF0000);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    drive_pix(10'd0, 10'd0, 1'b1);
    send_cmd(32'h3000_0007);
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: busy=%b required 0", busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: cmd_ready=%b required 1", cmd_ready);
    end
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL rst_mid_rgb: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef RESET_CLEAR_EN
    n = 0;
    while (!busy && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 1200) begin
      errors++;
      $display("FAIL rst_clear_len: busy cycles=%0d required 1200", n);
    end
    send_cmd(32'h4000_001F);
    drive_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h0000FF) begin
      errors++;
      $display("FAIL rst_clear_pix00: rgb=%h required %h", {red, green, blue}, 24'h0000FF);
    end
    drive_pix(10'd639, 10'd479, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h0000FF) begin
      errors++;
      $display("FAIL rst_clear_pixend: rgb=%h required %h", {red, green, blue}, 24'h0000FF);
    end
`else
    @(posedge clk);
    #1;
    n = 0;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%b ready=%b required 0 1", busy, cmd_ready);
    end
    drive_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL rst_pal_cleared: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
    send_cmd(32'h4070_001F);
    drive_pix(10'd0, 10'd0, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h0000FF) begin
      errors++;
      $display("FAIL rst_partial_head: rgb=%h required %h", {red, green, blue}, 24'h0000FF);
    end
    drive_pix(10'd639, 10'd479, 1'b1);
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      errors++;
      $display("FAIL rst_partial_tail: rgb=%h required %h", {red, green, blue}, 24'h000000);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_tile();
    test_blank();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
